// File: rtl/pipe_in_fifo.sv
// pipe_in_fifo: terminating PipeIn consumer; buffers enq beats and re-presents them as PipeOut first/deq.
module pipe_in_fifo #(
  parameter int width = 32,
  parameter int depth = 4,
  parameter int cntw = $clog2(depth) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [width-1:0] enq_v,
  output logic             enq__RDY,
  output logic [width-1:0] first,
  output logic             first__RDY,
  input  logic             deq__ENA,
  output logic             deq__RDY,
  output logic [cntw-1:0]  count,
  output logic             ovf,
  output logic             udf
);
  localparam int aw = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wrPtr, rdPtr;
  logic doEnq, doDeq;
  always_comb begin
    enq__RDY = count != cntw'(depth);
    deq__RDY = count != '0;
    first__RDY = deq__RDY;
    first = deq__RDY ? mem[rdPtr] : '0;
    doEnq = enq__ENA & enq__RDY;
    doDeq = deq__ENA & deq__RDY;
  end
  always_ff @(posedge CLK)
    if (doEnq) mem[wrPtr] <= enq_v;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (doEnq) wrPtr <= wrPtr + aw'(1);
      if (doDeq) rdPtr <= rdPtr + aw'(1);
      count <= count + cntw'(doEnq) - cntw'(doDeq);
      if (enq__ENA & ~enq__RDY & ~doDeq) ovf <= 1'b1;
      if (deq__ENA & ~deq__RDY & ~doEnq) udf <= 1'b1;
    end
endmodule
